// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD path: phase timing, FSM state codes and
// command class codes, plus phase-length helpers used by the nibble writer.
package lcd_pkg;

  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_EHIGH = 12;
  localparam int unsigned T_HOLD  = 1;
  localparam int unsigned T_GAP   = 50;
  localparam int unsigned T_WAIT  = 2000;
  localparam int unsigned T_CLEAR = 82000;

  localparam int unsigned CNT_W = 17;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StSetupH = 4'd1;
  localparam logic [3:0] StEH     = 4'd2;
  localparam logic [3:0] StHoldH  = 4'd3;
  localparam logic [3:0] StGap    = 4'd4;
  localparam logic [3:0] StSetupL = 4'd5;
  localparam logic [3:0] StEL     = 4'd6;
  localparam logic [3:0] StHoldL  = 4'd7;
  localparam logic [3:0] StWait   = 4'd8;

  localparam logic [3:0] CMD_DATA       = 4'b1010;
  localparam logic [3:0] CMD_SET_DDRAM  = 4'b1000;
  localparam logic [3:0] CMD_CLEAR      = 4'b0001;
  localparam logic [3:0] CMD_FUNC_SET   = 4'b0110;
  localparam logic [3:0] CMD_ENTRY_MODE = 4'b0011;
  localparam logic [3:0] CMD_DISPLAY_ON = 4'b0100;

  // Counter preload on entry to a state: phase length minus one.
  function automatic logic [CNT_W-1:0] phase_load(logic [3:0] st, logic clr);
    int unsigned len;
    case (st)
      StSetupH, StSetupL: len = T_SETUP;
      StEH, StEL:         len = T_EHIGH;
      StHoldH, StHoldL:   len = T_HOLD;
      StGap:              len = T_GAP;
      StWait:             len = clr ? T_CLEAR : T_WAIT;
      default:            len = 1;
    endcase
    return CNT_W'(len - 1);
  endfunction

  // States are encoded in transfer order, so the successor is the next code.
  function automatic logic [3:0] phase_next(logic [3:0] st);
    return (st == StWait) ? StIdle : st + 4'd1;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Serialises one LCD byte onto the 4-bit SF_D bus as two E-framed nibbles (upper first),
// then waits the controller execution time before accepting the next byte.
module lcd_nibble_writer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [7:0] DB,
  input  logic [3:0] instruction,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       busy,
  output logic       done
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             clr_q, clr_d;
  logic             start;

  logic [3:0] sf_d;
  logic       e_d, rs_out_d, busy_d, done_d;

  assign start = ready & ~ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (start) begin
        state_d = StSetupH;
        byte_d  = DB;
        rs_d    = (instruction == CMD_DATA);
        clr_d   = (DB == 8'h01) && (instruction == CMD_CLEAR);
        cnt_d   = phase_load(StSetupH, clr_d);
      end
    end else if (cnt_q == '0) begin
      state_d = phase_next(state_q);
      cnt_d   = phase_load(state_d, clr_q);
      done_d  = (state_q == StWait);
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs are derived from the next state so the registered pins line up with the FSM.
  always_comb begin
    sf_d = 4'h0;
    case (state_d)
      StSetupH, StEH, StHoldH, StGap: sf_d = byte_d[7:4];
      StSetupL, StEL, StHoldL:        sf_d = byte_d[3:0];
      default:                        sf_d = 4'h0;
    endcase
    e_d      = (state_d == StEH) || (state_d == StEL);
    rs_out_d = rs_d && (state_d != StIdle) && (state_d != StWait);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      clr_q   <= 1'b0;
      SF_D    <= 4'h0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      clr_q   <= clr_d;
      SF_D    <= sf_d;
      LCD_E   <= e_d;
      LCD_RS  <= rs_out_d;
      LCD_RW  <= 1'b0;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: directed transfers plus random bytes, every cycle compared
// against a timing-table model of the LCD write sequence.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [7:0] DB;
  logic [3:0] instruction;
  logic [3:0] SF_D;
  logic       LCD_E, LCD_RS, LCD_RW, busy, done;

  lcd_nibble_writer dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .DB          (DB),
    .instruction (instruction),
    .SF_D        (SF_D),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .busy        (busy),
    .done        (done)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: k counts cycles since the accept edge; kdone is the done-pulse cycle.
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_kdone = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_rs = 1'b0;
  bit         m_prev = 1'b0;
  int         acc_cyc = 0;
  int         done_seen = 0;
  int         last_done_cyc = 0;

  logic [3:0] codes [6] = '{4'b1010, 4'b1000, 4'b0110, 4'b0011, 4'b0100, 4'b0001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit         idle_now, start;
    logic [3:0] e_sf;
    bit         e_e, e_rs, e_busy, e_done;
    @(posedge clk);
    idle_now = !m_active || (m_k == m_kdone);
    start    = ready && !m_prev;
    if (reset) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
    end else begin
      if (idle_now && start) begin
        m_active = 1'b1;
        m_k      = 1;
        m_byte   = DB;
        m_rs     = (instruction == 4'b1010);
        m_kdone  = 81 + (((DB == 8'h01) && (instruction == 4'b0001)) ? 82000 : 2000);
        acc_cyc  = cyc + 1;
      end else if (m_active) begin
        m_k++;
        if (m_k > m_kdone) m_active = 1'b0;
      end
      m_prev = ready;
    end
    #1;
    cyc++;
    e_sf = 4'h0; e_e = 1'b0; e_rs = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active) begin
      if (m_k <= 65)      e_sf = m_byte[7:4];
      else if (m_k <= 80) e_sf = m_byte[3:0];
      e_e    = (m_k >= 3 && m_k <= 14) || (m_k >= 68 && m_k <= 79);
      e_rs   = m_rs && (m_k <= 80);
      e_busy = (m_k < m_kdone);
      e_done = (m_k == m_kdone);
    end
    check("pins{SF_D,E,RS,RW,busy,done}",
          32'({SF_D, LCD_E, LCD_RS, LCD_RW, busy, done}),
          32'({e_sf, e_e, e_rs, 1'b0, e_busy, e_done}));
    if (done === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 90000; i++) begin
      if (m_active && m_k == m_kdone) break;
      step();
    end
  endtask

  task automatic random_byte();
    DB          = 8'($urandom);
    instruction = codes[$urandom_range(0, 5)];
    if (instruction == 4'b0001 && DB == 8'h01) DB = 8'h02;
  endtask

  initial begin
    int d0;
    reset = 1'b1; ready = 1'b0; DB = 8'h00; instruction = 4'h0;
    repeat (3) step();
    check("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    repeat (2) step();

    // Function set, then a data byte raised in the done cycle (back to back).
    DB = 8'h28; instruction = 4'b0110; ready = 1'b1;
    step();
    ready = 1'b0;
    run_to_done();
    check("first_done_latency", 32'(last_done_cyc - acc_cyc + 1), 32'(2081));
    DB = 8'h41; instruction = 4'b1010; ready = 1'b1;
    d0 = cyc;
    step();
    ready = 1'b0;
    repeat (3) step();
    check("second_E_H_start", 32'(LCD_E), 32'(1));
    check("second_accept_cycle", 32'(acc_cyc - d0), 32'(1));
    run_to_done();
    repeat (3) step();

    // Ready held for two cycles plus a stray edge at cycle 500: one transfer only.
    d0 = done_seen;
    random_byte();
    ready = 1'b1;
    step(); step();
    ready = 1'b0;
    while (m_k < 499) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    run_to_done();
    repeat (5) step();
    check("single_done_count", 32'(done_seen - d0), 32'(1));

    // Reset during E_L aborts with no done pulse.
    d0 = done_seen;
    random_byte();
    ready = 1'b1;
    step();
    ready = 1'b0;
    while (m_k < 70) step();
    reset = 1'b1;
    step();
    check("abort_E", 32'(LCD_E), 32'(0));
    check("abort_SF_D", 32'(SF_D), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    repeat (2200) step();
    check("abort_no_done", 32'(done_seen - d0), 32'(0));

    random_byte();
    ready = 1'b1;
    step();
    ready = 1'b0;
    run_to_done();
    repeat (2) step();

    // Clear display uses the long wait.
    DB = 8'h01; instruction = 4'b0001; ready = 1'b1;
    step();
    ready = 1'b0;
    run_to_done();
    check("clear_done_latency", 32'(last_done_cyc - acc_cyc + 1), 32'(82081));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
